// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES core: start handshake, kld strobe, round stepping, done handshake.
// Build macro AES_CTRL_DEC_EN adds a dec input that makes round_idx count NR down to 1.
module aes_round_ctrl #(
    parameter int NR = 10,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    output logic          ld_ready,
`ifdef AES_CTRL_DEC_EN
    input  logic          dec,
`endif
    output logic          kld,
    output logic          round_en,
    output logic [CW-1:0] round_idx,
    output logic          first_rnd,
    output logic          last_rnd,
    output logic          done_valid,
    input  logic          done_ready,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

    localparam logic [CW-1:0] NR_C  = CW'(NR);
    localparam logic [CW-1:0] NR_P1 = CW'(NR + 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;

    generate
        if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
            $error("aes_round_ctrl: NR must be 10, 12 or 14");
        end
        if ((2 ** CW) <= NR) begin : g_bad_cw
            $error("aes_round_ctrl: CW too narrow for NR");
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cnt holds the round number; it must advance every ROUND cycle because rcon free-runs after kld
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case (state)
                LOAD:    cnt <= CW'(1);
                ROUND:   cnt <= (cnt == NR_C) ? '0 : cnt + CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef AES_CTRL_DEC_EN
    logic dec_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q <= 1'b0;
        end else if (state == IDLE && ld_valid) begin
            dec_q <= dec;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ld_valid) state_nxt = LOAD;
            LOAD:    state_nxt = ROUND;
            ROUND:   if (cnt == NR_C) state_nxt = DONE;
            DONE:    if (done_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // first/last track the position in the sequence, so they stay correct when round_idx counts down
    always_comb begin
        ld_ready   = (state == IDLE);
        busy       = (state != IDLE);
        kld        = 1'b0;
        round_en   = 1'b0;
        round_idx  = '0;
        first_rnd  = 1'b0;
        last_rnd   = 1'b0;
        done_valid = 1'b0;
        case (state)
            LOAD: kld = 1'b1;
            ROUND: begin
                round_en  = 1'b1;
`ifdef AES_CTRL_DEC_EN
                round_idx = dec_q ? (NR_P1 - cnt) : cnt;
`else
                round_idx = cnt;
`endif
                first_rnd = (cnt == CW'(1));
                last_rnd  = (cnt == NR_C);
            end
            DONE:    done_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: directed latency/handshake scenarios plus a randomized run
// compared against a phase-count model (phase = cycles elapsed since a start was accepted).
module tb_aes_round_ctrl;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ld_valid = 1'b0;
    logic done_ready = 1'b0;
`ifdef AES_CTRL_DEC_EN
    logic dec = 1'b0;
`endif

    int n_checks = 0;
    int n_fail = 0;

    // Output vectors: {ld_ready, kld, round_en, round_idx[3:0], first_rnd, last_rnd, done_valid, busy}
    wire [10:0] v10;
    wire [10:0] v14;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(10), .CW(CW)) u10 (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(v10[10]),
`ifdef AES_CTRL_DEC_EN
        .dec(1'b0),
`endif
        .kld(v10[9]), .round_en(v10[8]), .round_idx(v10[7:4]), .first_rnd(v10[3]),
        .last_rnd(v10[2]), .done_valid(v10[1]), .done_ready(done_ready), .busy(v10[0])
    );

    aes_round_ctrl #(.NR(14), .CW(CW)) u14 (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(v14[10]),
`ifdef AES_CTRL_DEC_EN
        .dec(1'b0),
`endif
        .kld(v14[9]), .round_en(v14[8]), .round_idx(v14[7:4]), .first_rnd(v14[3]),
        .last_rnd(v14[2]), .done_valid(v14[1]), .done_ready(done_ready), .busy(v14[0])
    );

`ifdef AES_CTRL_DEC_EN
    wire [10:0] v12;

    aes_round_ctrl #(.NR(12), .CW(CW)) u12 (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(v12[10]), .dec(dec),
        .kld(v12[9]), .round_en(v12[8]), .round_idx(v12[7:4]), .first_rnd(v12[3]),
        .last_rnd(v12[2]), .done_valid(v12[1]), .done_ready(done_ready), .busy(v12[0])
    );
`endif

    // Reference model: phase 0 idle, 1 key load, 2..NR+1 rounds, NR+2 waiting for done_ready
    int ph10 = 0;
    int ph14 = 0;
`ifdef AES_CTRL_DEC_EN
    int ph12 = 0;
    logic dm12 = 1'b0;
`endif

    function automatic int next_ph(int ph, int nr, logic r, logic lv, logic dr);
        if (r) return 0;
        if (ph == 0) return lv ? 1 : 0;
        if (ph <= nr + 1) return ph + 1;
        return dr ? 0 : ph;
    endfunction

    function automatic logic [10:0] exp_vec(int ph, int nr, logic d);
        int r;
        logic ren;
        logic [3:0] idx;
        r   = ph - 1;
        ren = (ph >= 2) && (ph <= nr + 1);
        idx = ren ? 4'(d ? nr + 1 - r : r) : 4'd0;
        return {ph == 0, ph == 1, ren, idx, ren && r == 1, ren && r == nr, ph == nr + 2, ph != 0};
    endfunction

    always @(posedge clk) begin
        ph10 <= next_ph(ph10, 10, rst, ld_valid, done_ready);
        ph14 <= next_ph(ph14, 14, rst, ld_valid, done_ready);
`ifdef AES_CTRL_DEC_EN
        ph12 <= next_ph(ph12, 12, rst, ld_valid, done_ready);
        if (!rst && ph12 == 0 && ld_valid) dm12 <= dec;
`endif
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        ld_valid = 1'b0;
        done_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ld_valid = 1'b1;
        done_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (v10 !== 11'h400) begin
                n_fail++;
                $display("[TB] FAIL reset_nr10 cycle %0d: got %b expected %b", c, v10, 11'h400);
            end
            n_checks++;
            if (v14 !== 11'h400) begin
                n_fail++;
                $display("[TB] FAIL reset_nr14 cycle %0d: got %b expected %b", c, v14, 11'h400);
            end
        end
        rst = 1'b0;
        ld_valid = 1'b0;
    endtask

    task automatic test_single_block();
        logic [10:0] exp;
        logic ren;
        apply_reset();
        done_ready = 1'b1;
        ld_valid = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            ld_valid = 1'b0;
            ren = (k >= 2) && (k <= 11);
            exp = {k == 13, k == 1, ren, ren ? 4'(k - 1) : 4'd0, k == 2, k == 11, k == 12, k <= 12};
            n_checks++;
            if (v10 !== exp) begin
                n_fail++;
                $display("[TB] FAIL single_block cycle %0d: got %b expected %b", k, v10, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        int waited;
        apply_reset();
        ld_valid = 1'b1;
        @(negedge clk);
        ld_valid = 1'b0;
        waited = 0;
        while (v10[1] !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (waited != 11) begin
            n_fail++;
            $display("[TB] FAIL bp_done_latency: got %0d cycles expected 11", waited);
        end
        ld_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (v10 !== 11'h003) begin
                n_fail++;
                $display("[TB] FAIL bp_hold cycle %0d: got %b expected %b", c, v10, 11'h003);
            end
        end
        done_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (v10 !== 11'h400) begin
            n_fail++;
            $display("[TB] FAIL bp_release_idle: got %b expected %b", v10, 11'h400);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        n_checks++;
        if (v10 !== 11'h201) begin
            n_fail++;
            $display("[TB] FAIL bp_restart_load: got %b expected %b", v10, 11'h201);
        end
    endtask

    task automatic test_mid_round_reset();
        int waited;
        apply_reset();
        done_ready = 1'b1;
        ld_valid = 1'b1;
        @(negedge clk);
        ld_valid = 1'b0;
        waited = 0;
        while (v10[7:4] !== 4'd6 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (waited != 6) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_reach6: got %0d cycles expected 6", waited);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (v10 !== 11'h400) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_idle: got %b expected %b", v10, 11'h400);
        end
        ld_valid = 1'b1;
        @(negedge clk);
        ld_valid = 1'b0;
        n_checks++;
        if (v10 !== 11'h201) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_kld: got %b expected %b", v10, 11'h201);
        end
        @(negedge clk);
        n_checks++;
        if (v10 !== 11'h119) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_round1: got %b expected %b", v10, 11'h119);
        end
    endtask

    task automatic test_back_to_back();
        int done_cyc[$];
        int kld_per[$];
        int klds;
        apply_reset();
        done_ready = 1'b1;
        ld_valid = 1'b1;
        klds = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (v14[9] === 1'b1) klds++;
            if (v14[1] === 1'b1) begin
                done_cyc.push_back(c);
                kld_per.push_back(klds);
                klds = 0;
            end
        end
        ld_valid = 1'b0;
        n_checks++;
        if (done_cyc.size() != 3) begin
            n_fail++;
            $display("[TB] FAIL b2b_done_count: got %0d expected 3", done_cyc.size());
        end
        for (int i = 0; i < done_cyc.size(); i++) begin
            n_checks++;
            if (done_cyc[i] != 16 + 17 * i) begin
                n_fail++;
                $display("[TB] FAIL b2b_done_cycle %0d: got %0d expected %0d", i, done_cyc[i], 16 + 17 * i);
            end
            n_checks++;
            if (kld_per[i] != 1) begin
                n_fail++;
                $display("[TB] FAIL b2b_kld_per_block %0d: got %0d expected 1", i, kld_per[i]);
            end
        end
    endtask

`ifdef AES_CTRL_DEC_EN
    task automatic test_decrypt();
        logic [10:0] exp;
        logic ren;
        apply_reset();
        done_ready = 1'b1;
        dec = 1'b1;
        ld_valid = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            ld_valid = 1'b0;
            dec = 1'b0;
            ren = (k >= 2) && (k <= 13);
            exp = {k == 15, k == 1, ren, ren ? 4'(14 - k) : 4'd0, k == 2, k == 13, k == 14, k <= 14};
            n_checks++;
            if (v12 !== exp) begin
                n_fail++;
                $display("[TB] FAIL decrypt cycle %0d: got %b expected %b", k, v12, exp);
            end
        end
    endtask
`endif

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            n_checks++;
            if (v10 !== exp_vec(ph10, 10, 1'b0)) begin
                n_fail++;
                $display("[TB] FAIL random_nr10 cycle %0d: got %b expected %b", c, v10, exp_vec(ph10, 10, 1'b0));
            end
            n_checks++;
            if (v14 !== exp_vec(ph14, 14, 1'b0)) begin
                n_fail++;
                $display("[TB] FAIL random_nr14 cycle %0d: got %b expected %b", c, v14, exp_vec(ph14, 14, 1'b0));
            end
`ifdef AES_CTRL_DEC_EN
            n_checks++;
            if (v12 !== exp_vec(ph12, 12, dm12)) begin
                n_fail++;
                $display("[TB] FAIL random_nr12 cycle %0d: got %b expected %b", c, v12, exp_vec(ph12, 12, dm12));
            end
            dec = 1'($urandom_range(0, 1));
`endif
            rst        = ($urandom_range(0, 99) == 0);
            ld_valid   = ($urandom_range(0, 3) == 0);
            done_ready = ($urandom_range(0, 2) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_backpressure();
        test_mid_round_reset();
        test_back_to_back();
`ifdef AES_CTRL_DEC_EN
        test_decrypt();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
